// File: rtl/dm_access_ctrl.sv
// Sequences M-stage loads/stores onto a variable-latency data-memory req/ack port,
// stalling the front pipeline and bubbling the M_WB write until the access completes.
module dm_access_ctrl #(
    parameter int                   data_size = 32,
    parameter int                   TIMEOUT   = 16,
    parameter logic [data_size-1:0] ERR_DATA  = 'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_MemRead,
    input  logic                 M_MemWrite,
    input  logic [data_size-1:0] M_ALU_result,
    input  logic [data_size-1:0] M_WriteData,
    output logic                 DM_req,
    output logic                 DM_we,
    output logic [data_size-1:0] DM_addr,
    output logic [data_size-1:0] DM_wdata,
    input  logic                 DM_ack,
    input  logic [data_size-1:0] DM_rdata,
    output logic                 stall,
    output logic                 MW_bubble,
    output logic [data_size-1:0] M_DM_Read_Data,
    output logic                 bus_err,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic                 req_n, we_n, err_n;
    logic [data_size-1:0] addr_n, wdata_n, rdata_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 access;

    assign access    = M_MemRead | M_MemWrite;
    assign MW_bubble = stall;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        req_n   = DM_req;
        we_n    = DM_we;
        addr_n  = DM_addr;
        wdata_n = DM_wdata;
        rdata_n = M_DM_Read_Data;
        err_n   = bus_err;
        cnt_n   = cnt;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall   = 1'b1;
                    state_n = REQ;
                    req_n   = 1'b1;
                    we_n    = M_MemWrite;  // read+write together resolves to a write
                    addr_n  = M_ALU_result;
                    wdata_n = M_WriteData;
                    cnt_n   = '0;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (DM_ack) begin
                    if (!DM_we) rdata_n = DM_rdata;
                    req_n   = 1'b0;
                    state_n = DONE;
                end else if (cnt == CNT_LAST) begin
                    if (!DM_we) rdata_n = ERR_DATA;
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                // One free cycle lets the access instruction retire; its M-stage
                // controls are still visible here and must not start a new access.
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            DM_req         <= 1'b0;
            DM_we          <= 1'b0;
            DM_addr        <= '0;
            DM_wdata       <= '0;
            M_DM_Read_Data <= '0;
            bus_err        <= 1'b0;
            cnt            <= '0;
        end else begin
            state          <= state_n;
            DM_req         <= req_n;
            DM_we          <= we_n;
            DM_addr        <= addr_n;
            DM_wdata       <= wdata_n;
            M_DM_Read_Data <= rdata_n;
            bus_err        <= err_n;
            cnt            <= cnt_n;
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed accesses push expected completions into a queue;
// a negedge monitor checks request stability during REQ and results at DONE.
module tb_dm_access_ctrl;

    localparam int TIMEOUT = 16;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        clk;
    logic        rst;
    logic        M_MemRead, M_MemWrite;
    logic [31:0] M_ALU_result, M_WriteData;
    logic        DM_req, DM_we;
    logic [31:0] DM_addr, DM_wdata;
    logic        DM_ack;
    logic [31:0] DM_rdata;
    logic        stall, MW_bubble;
    logic [31:0] M_DM_Read_Data;
    logic        bus_err;
    logic [1:0]  dbg_state;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   stall_run = 0;

    dm_access_ctrl #(.data_size(32), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
        .M_ALU_result(M_ALU_result), .M_WriteData(M_WriteData),
        .DM_req(DM_req), .DM_we(DM_we), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
        .DM_ack(DM_ack), .DM_rdata(DM_rdata),
        .stall(stall), .MW_bubble(MW_bubble),
        .M_DM_Read_Data(M_DM_Read_Data), .bus_err(bus_err),
        .dbg_state(dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            stall_run = 0;
        end else begin
            check("bubble_eq_stall", 32'(MW_bubble), 32'(stall));
            if (dbg_state == S_REQ && exp_q.size() > 0) begin
                check("req_high", 32'(DM_req), 32'd1);
                check("req_we", 32'(DM_we), 32'(exp_q[0].we));
                check("req_addr", DM_addr, exp_q[0].addr);
                check("req_wdata", DM_wdata, exp_q[0].wdata);
            end
            if (stall) begin
                stall_run++;
            end else if (dbg_state == S_DONE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_stalls", 32'(stall_run), 32'(e.stalls));
                    check("done_rdata", M_DM_Read_Data, e.rdata);
                    check("done_bus_err", 32'(bus_err), 32'(e.err));
                    check("done_req_low", 32'(DM_req), 32'd0);
                end
                stall_run = 0;
            end else begin
                stall_run = 0;
            end
        end
    end

    // driver: ack_dly = REQ cycle (1-based) carrying DM_ack; 0 = never ack
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_dly,
                             input logic [31:0] ack_data, input logic [31:0] exp_rdata,
                             input logic exp_err, input logic from_done);
        exp_t e;
        e.we     = wr;
        e.addr   = addr;
        e.wdata  = wdata;
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.stalls = 1 + ((ack_dly == 0) ? TIMEOUT : ack_dly);
        exp_q.push_back(e);
        M_MemRead    = rd;
        M_MemWrite   = wr;
        M_ALU_result = addr;
        M_WriteData  = wdata;
        if (from_done) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (ack_dly == 0) begin
            repeat (TIMEOUT) @(posedge clk);
            #1;
        end else begin
            repeat (ack_dly - 1) @(posedge clk);
            #1;
            DM_ack   = 1'b1;
            DM_rdata = ack_data;
            @(posedge clk); #1;
            DM_ack   = 1'b0;
            DM_rdata = 32'h0;
        end
    endtask

    task automatic go_idle();
        M_MemRead    = 1'b0;
        M_MemWrite   = 1'b0;
        M_ALU_result = 32'h0;
        M_WriteData  = 32'h0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        M_MemRead = 1'b0; M_MemWrite = 1'b0;
        M_ALU_result = 32'h0; M_WriteData = 32'h0;
        DM_ack = 1'b0; DM_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_req", 32'(DM_req), 32'd0);
        check("rst_we", 32'(DM_we), 32'd0);
        check("rst_addr", DM_addr, 32'h0);
        check("rst_wdata", DM_wdata, 32'h0);
        check("rst_rdata", M_DM_Read_Data, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // load, immediate ack
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        go_idle();
        // store, ack in 3rd REQ cycle; rdata bus junk must not be captured
        do_access(1'b0, 1'b1, 32'h80, 32'hCAFE_0001, 3, 32'hFFFF_0000, 32'h1234_5678, 1'b0, 1'b0);
        go_idle();
        // back-to-back loads
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h5A5A_0002, 32'h5A5A_0002, 1'b0, 1'b1);
        go_idle();
        // read and write together behave as a store
        do_access(1'b1, 1'b1, 32'h108, 32'h0000_BEEF, 2, 32'h1111_2222, 32'h5A5A_0002, 1'b0, 1'b0);
        go_idle();

        // spurious ack in IDLE
        DM_ack = 1'b1; DM_rdata = 32'h3333_4444;
        @(posedge clk); #1;
        DM_ack = 1'b0; DM_rdata = 32'h0;
        check("spur_state", 32'(dbg_state), 32'(S_IDLE));
        check("spur_stall", 32'(stall), 32'd0);
        check("spur_req", 32'(DM_req), 32'd0);
        check("spur_rdata", M_DM_Read_Data, 32'h5A5A_0002);

        // timeout load, then sticky bus_err on a normal load
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        go_idle();
        check("err_sticky_idle", 32'(bus_err), 32'd1);
        do_access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 1'b0);
        go_idle();

        // reset in the middle of an access, then a late ack
        M_MemRead = 1'b1; M_ALU_result = 32'h280;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_req_before", 32'(DM_req), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_req", 32'(DM_req), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(S_IDLE));
        check("abort_bus_err", 32'(bus_err), 32'd0);
        check("abort_rdata", M_DM_Read_Data, 32'h0);
        M_MemRead = 1'b0; M_ALU_result = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        DM_ack = 1'b1; DM_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        DM_ack = 1'b0; DM_rdata = 32'h0;
        check("late_ack_state", 32'(dbg_state), 32'(S_IDLE));
        check("late_ack_req", 32'(DM_req), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        check("late_ack_rdata", M_DM_Read_Data, 32'h0);
        check("late_ack_addr", DM_addr, 32'h0);

        // normal load after reset
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h7777_8888, 32'h7777_8888, 1'b0, 1'b0);
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
